proc_sequencer: RTL and testbench

Multi-cycle control sequencer for the 72-bit processor datapath. It replaces the free-running single-cycle control with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It handshakes with instruction memory and data memory, which may stall, and emits one-cycle enables for the PC, instruction register, register file and data memory. It sits between the instruction fetch unit and the rest of the datapath and also keeps a retired-instruction counter.

---
 rtl/proc_pkg.sv | 26 ++
 rtl/proc_sequencer_if.sv | 36 +++
 rtl/op_decode.sv | 22 ++
 rtl/proc_sequencer.sv | 135 +++++++++++++
 tb/tb_proc_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// state encoding, opcode class boundaries and PC source selects.
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
  } state_e;

  // Opcode classes: 0x0-0x7 R-type, 0x8-0xB I-type, then one opcode each.
  localparam logic [3:0] OP_IMM_FIRST = 4'h8;
  localparam logic [3:0] OP_IMM_LAST  = 4'hB;
  localparam logic [3:0] OP_LOAD      = 4'hC;
  localparam logic [3:0] OP_STORE     = 4'hD;
  localparam logic [3:0] OP_BRANCH    = 4'hE;
  localparam logic [3:0] OP_JUMP      = 4'hF;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

endpackage

// File: rtl/proc_sequencer_if.sv
// Handshake and control bundle between the sequencer and the datapath /
// memories. The sequencer uses the master view, the datapath the slave view.
interface proc_sequencer_if #(
  parameter int CNT_W = 32
) ();

  logic             run;
  logic [3:0]       opcode;
  logic             alu_flag;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_load;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             imm_sel;
  logic             rf_we;
  logic             wb_sel;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, alu_flag, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_load, pc_en, pc_sel,
           imm_sel, rf_we, wb_sel, busy, retired
  );

  modport slave (
    output run, opcode, alu_flag, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_load, pc_en, pc_sel,
           imm_sel, rf_we, wb_sel, busy, retired
  );

endinterface

// File: rtl/op_decode.sv
// Purely combinational opcode-to-class decoder. Every opcode belongs to
// exactly one class; I-type ops are also ALU ops and additionally set is_imm.
module op_decode
  import proc_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_alu_o,
  output logic       is_imm_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_jump_o
);

  assign is_alu_o    = (opcode_i <= OP_IMM_LAST);
  assign is_imm_o    = (opcode_i >= OP_IMM_FIRST) && (opcode_i <= OP_IMM_LAST);
  assign is_load_o   = (opcode_i == OP_LOAD);
  assign is_store_o  = (opcode_i == OP_STORE);
  assign is_branch_o = (opcode_i == OP_BRANCH);
  assign is_jump_o   = (opcode_i == OP_JUMP);

endmodule

// File: rtl/proc_sequencer.sv
// Moore sequencer stepping each instruction through fetch/decode/execute/
// memory/writeback, with memory handshakes and a retired-instruction counter.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  proc_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [3:0] cur_op;
  logic       is_alu, is_imm, is_load, is_store, is_branch, is_jump;

  logic       imem_req, dmem_req, dmem_we, ir_load, pc_en;
  logic [1:0] pc_sel;
  logic       imm_sel, rf_we, wb_sel;

  // The IR is stable from DECODE on; a private copy keeps later states
  // independent of whatever the datapath does with the IR afterwards.
  assign cur_op = (state_q == S_DECODE) ? bus.opcode : op_q;

  op_decode u_op_decode (
    .opcode_i    (cur_op),
    .is_alu_o    (is_alu),
    .is_imm_o    (is_imm),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .is_branch_o (is_branch),
    .is_jump_o   (is_jump)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = PC_INC;
    imm_sel  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d = bus.opcode;
        if (is_jump) begin
          pc_en   = 1'b1;
          pc_sel  = PC_JMP;
          state_d = bus.run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        imm_sel = is_imm | is_load | is_store;
        if (is_branch) begin
          pc_en   = 1'b1;
          pc_sel  = bus.alu_flag ? PC_BR : PC_INC;
          state_d = bus.run ? S_FETCH : S_IDLE;
        end else if (is_load || is_store) begin
          state_d = S_MEMORY;
        end else if (is_alu) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (bus.dmem_ack) begin
          if (is_store) begin
            pc_en   = 1'b1;
            state_d = bus.run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        rf_we   = 1'b1;
        wb_sel  = is_load;
        pc_en   = 1'b1;
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every instruction updates the PC exactly once, in its retire cycle.
  assign retired_d = retired_q + CNT_W'(pc_en);

  assign bus.imem_req = imem_req;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.ir_load  = ir_load;
  assign bus.pc_en    = pc_en;
  assign bus.pc_sel   = pc_sel;
  assign bus.imm_sel  = imm_sel;
  assign bus.rf_we    = rf_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: per-cycle input/expected-output tables
// for each instruction class, reset mid-access and counter wrap.
module tb_proc_sequencer;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  proc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  proc_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_retired = '0;

  // One row per clock cycle: inputs applied during that cycle and the
  // expected output vector {imem_req, ir_load, dmem_req, dmem_we, pc_en,
  // pc_sel[1:0], imm_sel, rf_we, wb_sel, busy}.
  typedef struct packed {
    logic        run;
    logic [3:0]  op;
    logic        ia;
    logic        da;
    logic        af;
    logic [10:0] exp;
  } row_t;

  function automatic row_t mk(logic run, logic [3:0] op, logic ia, logic da,
                              logic af, logic [10:0] exp);
    row_t r;
    r.run = run; r.op = op; r.ia = ia; r.da = da; r.af = af; r.exp = exp;
    return r;
  endfunction

  function automatic logic [10:0] outs();
    return {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.pc_en,
            bus.pc_sel, bus.imm_sel, bus.rf_we, bus.wb_sel, bus.busy};
  endfunction

  task automatic drive(row_t r);
    bus.run      = r.run;
    bus.opcode   = r.op;
    bus.imem_ack = r.ia;
    bus.dmem_ack = r.da;
    bus.alu_flag = r.af;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [10:0] O_IDLE   = 11'b0_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] O_FWAIT  = 11'b1_0_0_0_0_00_0_0_0_1;
  localparam logic [10:0] O_FACK   = 11'b1_1_0_0_0_00_0_0_0_1;
  localparam logic [10:0] O_BUSY   = 11'b0_0_0_0_0_00_0_0_0_1;
  localparam logic [10:0] O_EXIMM  = 11'b0_0_0_0_0_00_1_0_0_1;
  localparam logic [10:0] O_WB_ALU = 11'b0_0_0_0_1_00_0_1_0_1;
  localparam logic [10:0] O_WB_LD  = 11'b0_0_0_0_1_00_0_1_1_1;
  localparam logic [10:0] O_BR_T   = 11'b0_0_0_0_1_01_0_0_0_1;
  localparam logic [10:0] O_BR_NT  = 11'b0_0_0_0_1_00_0_0_0_1;
  localparam logic [10:0] O_MEM_RD = 11'b0_0_1_0_0_00_0_0_0_1;
  localparam logic [10:0] O_MEM_ST = 11'b0_0_1_1_1_00_0_0_0_1;
  localparam logic [10:0] O_JMP    = 11'b0_0_0_0_1_10_0_0_0_1;

  task automatic test_reset();
    rst = 1'b1;
    drive(mk(1'b1, 4'h3, 1'b1, 1'b1, 1'b1, O_IDLE));
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, O_IDLE));
    #1;
    n_checks++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected %b", outs(), O_IDLE);
    end
    n_checks++;
    if (bus.retired !== '0) begin
      n_fail++;
      $display("FAIL reset_retired: got %0d, expected 0", bus.retired);
    end
    $display("reset: outputs=%b retired=%0d", outs(), bus.retired);
    next_cycle();
  endtask

  task automatic test_alu();
    row_t rows [6];
    rows = '{mk(1, 4'h3, 1, 1, 0, O_IDLE),
             mk(0, 4'h3, 1, 1, 0, O_FACK),
             mk(0, 4'h3, 1, 1, 0, O_BUSY),
             mk(0, 4'h3, 1, 1, 0, O_BUSY),
             mk(0, 4'h3, 1, 1, 0, O_WB_ALU),
             mk(0, 4'h3, 1, 1, 0, O_IDLE)};
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      n_checks++;
      if (outs() !== rows[i].exp) begin
        n_fail++;
        $display("FAIL alu cycle %0d: got %b, expected %b", i, outs(), rows[i].exp);
      end
      next_cycle();
    end
    exp_retired = exp_retired + 1'b1;
    n_checks++;
    if (bus.retired !== exp_retired) begin
      n_fail++;
      $display("FAIL alu_retired: got %0d, expected %0d", bus.retired, exp_retired);
    end
    $display("alu op=0x3: retired=%0d", bus.retired);
  endtask

  task automatic test_branch();
    row_t rows [10];
    rows = '{mk(1, 4'hE, 1, 0, 1, O_IDLE),
             mk(0, 4'hE, 1, 0, 1, O_FACK),
             mk(0, 4'hE, 1, 0, 1, O_BUSY),
             mk(0, 4'hE, 1, 0, 1, O_BR_T),
             mk(0, 4'hE, 1, 0, 1, O_IDLE),
             mk(1, 4'hE, 1, 0, 0, O_IDLE),
             mk(0, 4'hE, 1, 0, 0, O_FACK),
             mk(0, 4'hE, 1, 0, 0, O_BUSY),
             mk(0, 4'hE, 1, 0, 0, O_BR_NT),
             mk(0, 4'hE, 1, 0, 0, O_IDLE)};
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      n_checks++;
      if (outs() !== rows[i].exp) begin
        n_fail++;
        $display("FAIL branch cycle %0d: got %b, expected %b", i, outs(), rows[i].exp);
      end
      next_cycle();
    end
    exp_retired = exp_retired + 2'd2;
    n_checks++;
    if (bus.retired !== exp_retired) begin
      n_fail++;
      $display("FAIL branch_retired: got %0d, expected %0d", bus.retired, exp_retired);
    end
    $display("branch taken/not-taken: retired=%0d", bus.retired);
  endtask

  task automatic test_load_stall();
    row_t rows [10];
    int   busy_cycles;
    rows = '{mk(1, 4'hC, 1, 0, 0, O_IDLE),
             mk(0, 4'hC, 1, 0, 0, O_FACK),
             mk(0, 4'hC, 1, 0, 0, O_BUSY),
             mk(0, 4'hC, 1, 0, 0, O_EXIMM),
             mk(0, 4'hC, 1, 0, 0, O_MEM_RD),
             mk(0, 4'hC, 1, 0, 0, O_MEM_RD),
             mk(0, 4'hC, 1, 0, 0, O_MEM_RD),
             mk(0, 4'hC, 1, 1, 0, O_MEM_RD),
             mk(0, 4'hC, 1, 0, 0, O_WB_LD),
             mk(0, 4'hC, 1, 0, 0, O_IDLE)};
    busy_cycles = 0;
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      if (bus.busy === 1'b1) busy_cycles++;
      n_checks++;
      if (outs() !== rows[i].exp) begin
        n_fail++;
        $display("FAIL load cycle %0d: got %b, expected %b", i, outs(), rows[i].exp);
      end
      next_cycle();
    end
    n_checks++;
    if (busy_cycles != 8) begin
      n_fail++;
      $display("FAIL load_latency: got %0d cycles, expected 8", busy_cycles);
    end
    exp_retired = exp_retired + 1'b1;
    n_checks++;
    if (bus.retired !== exp_retired) begin
      n_fail++;
      $display("FAIL load_retired: got %0d, expected %0d", bus.retired, exp_retired);
    end
    $display("load with 3 dmem wait cycles: latency=%0d retired=%0d", busy_cycles, bus.retired);
  endtask

  task automatic test_back_to_back();
    row_t rows [9];
    rows = '{mk(1, 4'hD, 0, 1, 0, O_IDLE),
             mk(1, 4'hD, 0, 1, 0, O_FWAIT),
             mk(1, 4'hD, 1, 1, 0, O_FACK),
             mk(1, 4'hD, 1, 1, 0, O_BUSY),
             mk(1, 4'hD, 1, 1, 0, O_EXIMM),
             mk(1, 4'hD, 1, 1, 0, O_MEM_ST),
             mk(0, 4'hF, 1, 1, 0, O_FACK),
             mk(0, 4'hF, 1, 1, 0, O_JMP),
             mk(0, 4'hF, 1, 1, 0, O_IDLE)};
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      n_checks++;
      if (outs() !== rows[i].exp) begin
        n_fail++;
        $display("FAIL store_jump cycle %0d: got %b, expected %b", i, outs(), rows[i].exp);
      end
      next_cycle();
    end
    exp_retired = exp_retired + 2'd2;
    n_checks++;
    if (bus.retired !== exp_retired) begin
      n_fail++;
      $display("FAIL store_jump_retired: got %0d, expected %0d", bus.retired, exp_retired);
    end
    $display("store then jump: retired=%0d", bus.retired);
  endtask

  task automatic test_reset_mid_access();
    row_t rows [5];
    rows = '{mk(1, 4'hC, 1, 0, 0, O_IDLE),
             mk(0, 4'hC, 1, 0, 0, O_FACK),
             mk(0, 4'hC, 1, 0, 0, O_BUSY),
             mk(0, 4'hC, 1, 0, 0, O_EXIMM),
             mk(0, 4'hC, 1, 0, 0, O_MEM_RD)};
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      n_checks++;
      if (outs() !== rows[i].exp) begin
        n_fail++;
        $display("FAIL rst_mid cycle %0d: got %b, expected %b", i, outs(), rows[i].exp);
      end
      next_cycle();
    end
    rst = 1'b1;
    drive(mk(1, 4'hC, 1, 1, 0, O_MEM_RD));
    #1;
    n_checks++;
    if (outs() !== O_MEM_RD) begin
      n_fail++;
      $display("FAIL rst_mid_pre_edge: got %b, expected %b", outs(), O_MEM_RD);
    end
    next_cycle();
    rst = 1'b0;
    drive(mk(0, 4'hC, 1, 1, 0, O_IDLE));
    #1;
    exp_retired = '0;
    n_checks++;
    if (outs() !== O_IDLE) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b, expected %b", outs(), O_IDLE);
    end
    n_checks++;
    if (bus.retired !== exp_retired) begin
      n_fail++;
      $display("FAIL rst_mid_retired: got %0d, expected 0", bus.retired);
    end
    $display("reset during memory wait: outputs=%b retired=%0d", outs(), bus.retired);
    next_cycle();
  endtask

  task automatic test_wrap();
    drive(mk(1, 4'hF, 1, 0, 0, O_IDLE));
    next_cycle();
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      n_checks++;
      if (outs() !== O_JMP) begin
        n_fail++;
        $display("FAIL wrap_jump %0d: got %b, expected %b", i, outs(), O_JMP);
      end
      next_cycle();
      exp_retired = exp_retired + 1'b1;
    end
    n_checks++;
    if (bus.retired !== 4'hF || exp_retired !== 4'hF) begin
      n_fail++;
      $display("FAIL wrap_all_ones: got %0d, expected %0d", bus.retired, exp_retired);
    end
    bus.run = 1'b0;
    next_cycle();
    next_cycle();
    exp_retired = exp_retired + 1'b1;
    n_checks++;
    if (bus.retired !== exp_retired) begin
      n_fail++;
      $display("FAIL wrap_to_zero: got %0d, expected %0d", bus.retired, exp_retired);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_idle: busy=%b, expected 0", bus.busy);
    end
    $display("16 jumps: retired=%0d", bus.retired);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(mk(0, 4'h0, 0, 0, 0, O_IDLE));
    test_reset();
    test_alu();
    test_branch();
    test_load_stall();
    test_back_to_back();
    test_reset_mid_access();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
